fetch_unit: RTL

Instruction-fetch stage that sits directly upstream of the synchronous instruction memory and feeds the decode stage. It owns the program counter and drives the memory address. It aligns the returned 16-bit instruction with its PC and a valid bit, and handles decode stalls and branch/jump redirects. It also keeps a small return-address stack for call/return.

---
 rtl/pipeline_pkg.sv | 34 +++
 rtl/return_stack.sv | 51 +++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths, reset PC and instruction-encoding constants
package pipeline_pkg;

    localparam int                WORD_W           = 16;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        AND = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2,
        SV  = 2'd3
    } opcode_e;

    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R4 = 3'd4;
    localparam logic [2:0] R5 = 3'd5;
    localparam logic [2:0] R6 = 3'd6;
    localparam logic [2:0] R7 = 3'd7;

    // Layout: op[15:14] rd[13:11] rs1[10:8] rs2[7:5] imm[4:0]
    function automatic logic [WORD_W-1:0] make_instr(
        input opcode_e    op,
        input logic [2:0] rd,
        input logic [2:0] rs1,
        input logic [2:0] rs2,
        input logic [4:0] imm
    );
        return {op, rd, rs1, rs2, imm};
    endfunction

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - circular return-address stack that overwrites its oldest entry when full
module return_stack
    import pipeline_pkg::*;
#(
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] push_data,
    output logic [WORD_W-1:0] top,
    output logic              empty
);

    localparam int                PTR_W = $clog2(RAS_DEPTH);
    localparam int                CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(RAS_DEPTH);

    logic [WORD_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_top_idx;

    // r_ptr is the next free slot; it wraps naturally because the depth is a power of two
    assign w_top_idx = r_ptr - 1'b1;
    assign top       = r_mem[w_top_idx];
    assign empty     = (r_count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_count != FULL) begin
                r_count <= r_count + 1'b1;
            end
        end else if (pop && !empty) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and instruction-fetch stage with stall hold, redirects and call/return
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_instr,
    input  logic              id_stall,
    input  logic              id_redirect,
    input  logic [WORD_W-1:0] id_target,
    input  logic              id_call,
    input  logic              id_ret,
    input  logic              ex_redirect,
    input  logic [WORD_W-1:0] ex_target,
    output logic [WORD_W-1:0] id_instr,
    output logic [WORD_W-1:0] id_pc,
    output logic              id_valid,
    output logic              ras_underflow
);

    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_fpc;
    logic              r_fvalid;
    logic [WORD_W-1:0] r_hold;
    logic              r_hold_sel;
    logic              r_uflow;

    logic [WORD_W-1:0] w_pc_nxt;
    logic [WORD_W-1:0] w_fpc_nxt;
    logic              w_fvalid_nxt;
    logic [WORD_W-1:0] w_hold_nxt;
    logic              w_hold_sel_nxt;
    logic              w_uflow_nxt;
    logic              w_push;
    logic              w_pop;
    logic [WORD_W-1:0] w_ras_top;
    logic              w_ras_empty;

    return_stack #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (r_fpc + 16'd1),
        .top       (w_ras_top),
        .empty     (w_ras_empty)
    );

    assign imem_addr     = r_pc;
    assign id_instr      = r_hold_sel ? r_hold : imem_instr;
    assign id_pc         = r_fpc;
    assign id_valid      = r_fvalid;
    assign ras_underflow = r_uflow;

    // Any redirect turns the fetch already in flight (address r_pc) into a bubble
    always_comb begin
        w_pc_nxt       = r_pc;
        w_fpc_nxt      = r_fpc;
        w_fvalid_nxt   = r_fvalid;
        w_hold_nxt     = r_hold;
        w_hold_sel_nxt = r_hold_sel;
        w_uflow_nxt    = 1'b0;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        if (ex_redirect) begin
            w_pc_nxt       = ex_target;
            w_fpc_nxt      = r_pc;
            w_fvalid_nxt   = 1'b0;
            w_hold_sel_nxt = 1'b0;
        end else if (id_stall) begin
            // Memory keeps returning the next address, so capture the presented word once
            if (!r_hold_sel) begin
                w_hold_nxt     = imem_instr;
                w_hold_sel_nxt = 1'b1;
            end
        end else if (id_ret) begin
            w_fpc_nxt      = r_pc;
            w_fvalid_nxt   = 1'b0;
            w_hold_sel_nxt = 1'b0;
            if (w_ras_empty) begin
                w_pc_nxt    = '0;
                w_uflow_nxt = 1'b1;
            end else begin
                w_pc_nxt = w_ras_top;
                w_pop    = 1'b1;
            end
        end else if (id_redirect) begin
            w_pc_nxt       = id_target;
            w_fpc_nxt      = r_pc;
            w_fvalid_nxt   = 1'b0;
            w_hold_sel_nxt = 1'b0;
            w_push         = id_call;
        end else begin
            w_pc_nxt       = r_pc + 16'd1;
            w_fpc_nxt      = r_pc;
            w_fvalid_nxt   = 1'b1;
            w_hold_sel_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_fpc      <= '0;
            r_fvalid   <= 1'b0;
            r_hold     <= '0;
            r_hold_sel <= 1'b0;
            r_uflow    <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_fpc      <= w_fpc_nxt;
            r_fvalid   <= w_fvalid_nxt;
            r_hold     <= w_hold_nxt;
            r_hold_sel <= w_hold_sel_nxt;
            r_uflow    <= w_uflow_nxt;
        end
    end

endmodule
